// File: rtl/instr_fifo_if.sv
// Valid/ready bundle between the external interface and the controller.
// master drives words in and consumes the head; slave is the queue.
interface instr_fifo_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );
endinterface

// File: rtl/instr_fifo.sv
// Parametrised first-word-fall-through instruction queue with flush and sticky errors.
// Optional peak-occupancy register enabled by INSTR_FIFO_WATERMARK_EN.
module instr_fifo #(
  parameter  int DATA_WIDTH = 64,
  parameter  int DEPTH      = 64,
  parameter  int AF_THRESH  = DEPTH - 4,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  instr_fifo_if.slave         bus,
  output logic [ADDR_WIDTH:0] count,
  output logic                almost_full,
  output logic                err_overflow,
  output logic                err_underflow,
  output logic [ADDR_WIDTH:0] max_count
);

  localparam logic [ADDR_WIDTH:0]   FULL_CNT = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AF_CNT   = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] head_q, head_d;
  logic [ADDR_WIDTH-1:0] tail_q, tail_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Flush wins, so neither pointer nor storage moves in a flush cycle.
  assign push = bus.in_valid && !full && !flush;
  assign pop  = bus.out_ready && !empty && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (push) tail_d = tail_q + PTR_ONE;
      if (pop)  head_d = head_q + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (bus.in_valid && full)   ovf_d = 1'b1;
      if (bus.out_ready && empty) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= bus.in_data;
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = mem_q[head_q];

  assign count         = count_q;
  assign almost_full   = (count_q >= AF_CNT);
  assign err_overflow  = ovf_q;
  assign err_underflow = udf_q;

`ifdef INSTR_FIFO_WATERMARK_EN
  logic [ADDR_WIDTH:0] max_q, max_d;

  always_comb begin
    max_d = max_q;
    if (flush)                max_d = '0;
    else if (count_d > max_q) max_d = count_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) max_q <= '0;
    else      max_q <= max_d;
  end

  assign max_count = max_q;
`else
  assign max_count = '0;
`endif

endmodule

// File: tb/tb_instr_fifo.sv
// Directed bench for instr_fifo at DEPTH=8, AF_THRESH=6, 16-bit words.
// Define INSTR_FIFO_WATERMARK_EN for both DUT and bench to test the watermark.
module tb_instr_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AFT   = 6;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic          flush;
  logic [AW:0]   count;
  logic          almost_full;
  logic          err_overflow;
  logic          err_underflow;
  logic [AW:0]   max_count;

  int total;
  int passed;

  instr_fifo_if #(.DATA_WIDTH(DW)) bus ();

  instr_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .AF_THRESH (AFT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .bus          (bus),
    .count        (count),
    .almost_full  (almost_full),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow),
    .max_count    (max_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_head;

  initial begin
    total  = 0;
    passed = 0;
    rst    = 1'b0;
    flush  = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_ovf", 32'(err_overflow), 0);
    chk("rst_udf", 32'(err_underflow), 0);
    chk("rst_max", 32'(max_count), 0);
    @(negedge clk);
    rst = 1'b1;

    // Fill 1..8 with no consumer
    for (int i = 1; i <= 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(i);
      tick();
      chk($sformatf("fill_count_%0d", i), 32'(count), 32'(i));
      chk($sformatf("fill_af_%0d", i), 32'(almost_full), (i >= 6) ? 1 : 0);
      chk($sformatf("fill_rdy_%0d", i), 32'(bus.in_ready), (i < 8) ? 1 : 0);
    end
    bus.in_data = 16'h9;
    tick();
    chk("ovf_set", 32'(err_overflow), 1);
    chk("ovf_count", 32'(count), 8);
    bus.in_valid = 1'b0;
`ifdef INSTR_FIFO_WATERMARK_EN
    chk("max_full", 32'(max_count), 8);
`else
    chk("max_full", 32'(max_count), 0);
`endif

    // Drain in order
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_valid_%0d", i), 32'(bus.out_valid), 1);
      chk($sformatf("drain_data_%0d", i), 32'(bus.out_data), 32'(i));
      tick();
    end
    chk("drain_count", 32'(count), 0);
    chk("drain_valid_end", 32'(bus.out_valid), 0);
    chk("drain_udf_clear", 32'(err_underflow), 0);
    tick();
    chk("udf_set", 32'(err_underflow), 1);
    chk("ovf_sticky", 32'(err_overflow), 1);
    bus.out_ready = 1'b0;

    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush1_ovf", 32'(err_overflow), 0);
    chk("flush1_udf", 32'(err_underflow), 0);

    // Wrap-around at steady count 3
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 16'(32'h100 + i);
      tick();
    end
    chk("wrap_pre_count", 32'(count), 3);
    exp_head = 32'h100;
    bus.out_ready = 1'b1;
    for (int i = 3; i < 23; i++) begin
      bus.in_data = 16'(32'h100 + i);
      chk($sformatf("wrap_data_%0d", i), 32'(bus.out_data), 32'(exp_head));
      tick();
      exp_head++;
      chk($sformatf("wrap_count_%0d", i), 32'(count), 3);
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wrap_tail_%0d", i), 32'(bus.out_data), 32'(exp_head));
      tick();
      exp_head++;
    end
    chk("wrap_empty", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b0;

    // Push into an empty queue with out_ready high
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'hDEAD;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("byp_count", 32'(count), 1);
    chk("byp_valid", 32'(bus.out_valid), 1);
    chk("byp_data", 32'(bus.out_data), 32'hDEAD);
    chk("byp_udf", 32'(err_underflow), 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("byp_drained", 32'(count), 0);

    // Flush beats simultaneous push and pop
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 16'(32'h50 + i);
      tick();
    end
    chk("pre_flush_count", 32'(count), 5);
    chk("pre_flush_udf", 32'(err_underflow), 1);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(bus.out_valid), 0);
    chk("flush_ovf", 32'(err_overflow), 0);
    chk("flush_udf", 32'(err_underflow), 0);
    chk("flush_max", 32'(max_count), 0);

    // Asynchronous reset between edges
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 16'(32'h70 + i);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("refill_count", 32'(count), 4);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_in_ready", 32'(bus.in_ready), 1);
    chk("arst_valid", 32'(bus.out_valid), 0);
    #2;
    rst = 1'b1;

    // Watermark: push 5, pop 3, push 1
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 16'(32'h200 + i);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h205;
    tick();
    bus.in_valid  = 1'b0;
    chk("wm_count", 32'(count), 3);
    chk("wm_head", 32'(bus.out_data), 32'h203);
`ifdef INSTR_FIFO_WATERMARK_EN
    chk("wm_max", 32'(max_count), 5);
`else
    chk("wm_max", 32'(max_count), 0);
`endif
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("wm_flush_max", 32'(max_count), 0);
    chk("wm_flush_count", 32'(count), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_fifo.md
# instr_fifo

Parametrised instruction queue between the external interface and the controller, successor to the fixed 64x64 instruction buffer. It has one clock domain, width and depth set by parameters, and valid/ready handshakes on both sides, so no word is ever written while full or popped while empty. It also provides occupancy count, an almost-full flag, a synchronous flush and sticky overflow/underflow error flags.

## Interface
- DATA_WIDTH, 64: instruction word width in bits.
- DEPTH, 64: number of entries; must be a power of two, at least 2.
- ADDR_WIDTH, $clog2(DEPTH): pointer width; derived, not overridden.
- AF_THRESH, DEPTH-4: almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of contents, active-high.
- in_data  input  DATA_WIDTH  instruction from interface.
- in_valid  input  1  producer has a word.
- in_ready  output  1  queue can accept; equals !full.
- out_data  output  DATA_WIDTH  head entry (first-word-fall-through).
- out_valid  output  1  head entry valid; equals !empty.
- out_ready  input  1  controller consumes head this cycle.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- almost_full  output  1  count >= AF_THRESH.
- err_overflow  output  1  sticky: in_valid seen while full.
- err_underflow  output  1  sticky: out_ready seen while empty.
- max_count  output  ADDR_WIDTH+1  peak occupancy (see Configuration).

## Operation
- Storage: DEPTH x DATA_WIDTH array, head/tail pointers of ADDR_WIDTH bits that wrap naturally at DEPTH, and a count register of ADDR_WIDTH+1 bits.
- Push happens when in_valid && in_ready. It writes mem[tail] and increments tail.
- Pop happens when out_valid && out_ready. It increments head.
- Count update: push only gives +1, pop only gives -1, push and pop together leave count unchanged.
- out_data = mem[head], combinational from the registered head. Its value is undefined (X is allowed) when out_valid=0.
- Full (count==DEPTH) drops in_ready. A push attempted while full is not accepted: storage and pointers are unchanged and err_overflow is set.
- Empty (count==0) drops out_valid. A pop attempted while empty has no effect and sets err_underflow.
- There is no full-to-full pass-through. Pop and push in the same cycle while full is only a pop, because in_ready=0.
- Pop and push in the same cycle while empty is only a push. The word becomes visible the next cycle.
- Flush has priority over push and pop in the same cycle. It zeroes head, tail and count, and clears both error flags. Array contents are not cleared.
- The error flags hold until reset or flush.

## Timing
- Reset (rst=0, asynchronous) sets head=0, tail=0, count=0, in_ready=1, out_valid=0, almost_full=0, err_overflow=0, err_underflow=0 and max_count=0. out_data is undefined.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Deassertion is sampled at the next clk edge, and the first push is accepted at that edge.
- Write-to-read latency is 1 cycle: a word pushed at edge N gives out_valid=1 with that word on out_data after edge N.
- in_ready, out_valid, almost_full and count are all registered or derived only from count. None depends combinationally on in_valid or out_ready.
- Throughput is one push and one pop per cycle sustained when the queue is neither empty nor full.

## Configuration
- INSTR_FIFO_WATERMARK_EN defined:
  - max_count holds the highest count value reached since the last reset or flush.
  - It is updated each cycle as max(max_count, next count).
- INSTR_FIFO_WATERMARK_EN undefined:
  - The max_count port still exists, tied to 0.
  - No watermark register is synthesised.

## Test plan
- Reset then fill, DEPTH=8, AF_THRESH=6:
  - Push 0x1..0x8 on consecutive cycles, with out_ready=0.
  - Required: almost_full rises after the 6th push, in_ready=0 after the 8th, count=8.
  - A 9th in_valid sets err_overflow=1 and count stays 8.
- Drain:
  - From full, hold out_ready=1.
  - Required: out_data reads 0x1..0x8 in order, one per cycle, then out_valid=0 and count=0.
  - One further out_ready sets err_underflow=1.
- Wrap-around:
  - DEPTH=8; push and pop simultaneously for 20 cycles at count=3, with data 0x100+i.
  - Required: count stays 3 throughout and output order is intact across the pointer wrap.
- Empty bypass timing:
  - Empty queue; push 0xDEAD with out_ready=1 in the same cycle.
  - Required: no pop that cycle; next cycle out_valid=1 and out_data=0xDEAD.
- Flush and reset mid-operation:
  - At count=5 with an error flag set, assert flush together with push and pop.
  - Required next cycle: count=0, out_valid=0, flags=0.
  - Refill to 4, then pulse rst low between edges.
  - Required: count=0 and in_ready=1 immediately, before the next edge.
- Watermark, built with INSTR_FIFO_WATERMARK_EN:
  - Push 5, pop 3, push 1.
  - Required: max_count=5. After flush, max_count=0.
  - Built without the macro: max_count=0 throughout.
